// File: rtl/pulse_meas.sv
// rtl/pulse_meas.sv - discrete-input pulse width/period measurement with glitch filter and valid/ready result
module pulse_meas #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_W       = 4,
    parameter int PCNT_W      = 16
) (
    input  logic              clk_in,
    input  logic              rst_board,
    input  logic              clr,
    input  logic              ena,
    input  logic              din,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic [CNT_W-1:0]  meas_width,
    output logic [CNT_W-1:0]  meas_period,
    output logic              meas_sat,
    output logic              lost,
    output logic [PCNT_W-1:0] pulse_cnt
);

    localparam int STAB_W = (MIN_W > 1) ? $clog2(MIN_W) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(MIN_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   din_s;
    logic [STAB_W-1:0]      stab;
    logic                   filt;
    logic                   filt_d;
    logic                   rise;
    logic                   fall;

    logic [1:0]             state;
    logic [CNT_W-1:0]       wcnt;
    logic [CNT_W-1:0]       pcnt;
    logic [CNT_W-1:0]       width_r;
    logic [CNT_W-1:0]       wcnt_inc;
    logic [CNT_W-1:0]       pcnt_inc;
    logic                   load;
    logic                   sat_new;

    assign din_s = sync_r[SYNC_STAGES-1];
    assign rise  = filt & ~filt_d;
    assign fall  = ~filt & filt_d;

    always_ff @(posedge clk_in or negedge rst_board) begin
        if (!rst_board) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // filt only follows din_s once it has differed for MIN_W consecutive cycles,
    // so both edges see the same delay and accepted pulses keep their width.
    always_ff @(posedge clk_in or negedge rst_board) begin
        if (!rst_board) begin
            stab   <= '0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            filt_d <= filt;
            if (clr || (din_s == filt)) begin
                stab <= '0;
            end else if (stab == STAB_MAX) begin
                filt <= din_s;
                stab <= '0;
            end else begin
                stab <= stab + STAB_W'(1);
            end
        end
    end

    always_comb begin
        wcnt_inc = (wcnt == CNT_MAX) ? wcnt : wcnt + CNT_ONE;
        pcnt_inc = (pcnt == CNT_MAX) ? pcnt : pcnt + CNT_ONE;
        load     = ena && (state == ST_LOW) && rise;
        sat_new  = (width_r == CNT_MAX) || (pcnt == CNT_MAX);
    end

    always_ff @(posedge clk_in or negedge rst_board) begin
        if (!rst_board) begin
            state       <= ST_IDLE;
            wcnt        <= '0;
            pcnt        <= '0;
            width_r     <= '0;
            meas_valid  <= 1'b0;
            meas_width  <= '0;
            meas_period <= '0;
            meas_sat    <= 1'b0;
            lost        <= 1'b0;
            pulse_cnt   <= '0;
        end else if (clr) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            pcnt       <= '0;
            width_r    <= '0;
            meas_valid <= 1'b0;
            lost       <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            if (rise && ena) begin
                pulse_cnt <= pulse_cnt + PCNT_W'(1);
            end

            // A fresh result always wins; an unaccepted one being replaced is flagged.
            if (load) begin
                meas_width  <= width_r;
                meas_period <= pcnt;
                meas_sat    <= sat_new;
                meas_valid  <= 1'b1;
                if (meas_valid && !meas_ready) begin
                    lost <= 1'b1;
                end
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end

            if (!ena) begin
                state <= ST_IDLE;
                wcnt  <= '0;
                pcnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state <= ST_HIGH;
                            wcnt  <= CNT_ONE;
                            pcnt  <= CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        wcnt <= wcnt_inc;
                        pcnt <= pcnt_inc;
                        if (fall) begin
                            width_r <= wcnt;
                            state   <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            state <= ST_HIGH;
                            wcnt  <= CNT_ONE;
                            pcnt  <= CNT_ONE;
                        end else begin
                            pcnt <= pcnt_inc;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
